// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master round-robin arbiter in front of a single MMIO
// slave port. Each transaction runs IDLE -> ISSUE -> RESP. A master can hold
// the grant across transactions (lock) for an atomic read-modify-write. If the
// lock owner stops requesting, the lock is released after LOCK_TIMEOUT idle
// cycles.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 3'd1
`endif
`ifndef MEM_COUNT_HALF
`define MEM_COUNT_HALF 3'd2
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif

module mmio_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16,
    parameter int unsigned LOCK_CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    aresetn,
    // master 0
    input  logic                    i_m0_req,
    input  logic [`ADDR_W-1:0]      i_m0_addr,
    input  logic [`WORD_W-1:0]      i_m0_wr_data,
    input  logic                    i_m0_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_m0_count,
    input  logic                    i_m0_lock,
    output logic                    o_m0_ack,
    output logic [`WORD_W-1:0]      o_m0_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_m0_code,
    // master 1
    input  logic                    i_m1_req,
    input  logic [`ADDR_W-1:0]      i_m1_addr,
    input  logic [`WORD_W-1:0]      i_m1_wr_data,
    input  logic                    i_m1_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_m1_count,
    input  logic                    i_m1_lock,
    output logic                    o_m1_ack,
    output logic [`WORD_W-1:0]      o_m1_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_m1_code,
    // slave port
    output logic [`ADDR_W-1:0]      o_req_addr,
    output logic [`WORD_W-1:0]      o_req_wr_data,
    output logic                    o_req_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_req_count,
    input  logic [`WORD_W-1:0]      i_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]  i_res_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [LOCK_CNT_W-1:0] CNT_ZERO  = {LOCK_CNT_W{1'b0}};
    localparam logic [LOCK_CNT_W-1:0] CNT_ONE   = LOCK_CNT_W'(1);

    state_e                  state_q, state_d;
    logic                    rr_q, rr_d;             // 0: m0 wins a tie, 1: m1 wins
    logic                    gnt_q, gnt_d;           // id of master owning the current transaction
    logic                    lock_q, lock_d;
    logic                    lock_own_q, lock_own_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [`ADDR_W-1:0]      req_addr_q, req_addr_d;
    logic [`WORD_W-1:0]      req_wr_data_q, req_wr_data_d;
    logic                    req_wr_en_q, req_wr_en_d;
    logic [`MEM_COUNT_W-1:0] req_count_q, req_count_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;

    logic                    m0_elig_s;
    logic                    m1_elig_s;
    logic                    grant_vld_s;
    logic                    grant_id_s;
    logic                    owner_req_s;

    // Eligibility and round-robin choice; while locked only the owner may win.
    always_comb begin
        m0_elig_s   = i_m0_req & (~lock_q | ~lock_own_q);
        m1_elig_s   = i_m1_req & (~lock_q |  lock_own_q);
        owner_req_s = lock_own_q ? i_m1_req : i_m0_req;
        grant_vld_s = m0_elig_s | m1_elig_s;
        if (m0_elig_s && m1_elig_s) begin
            grant_id_s = rr_q;
        end else if (m1_elig_s) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Next-state logic for the transaction sequencer, lock and slave request copy.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        gnt_d         = gnt_q;
        lock_d        = lock_q;
        lock_own_d    = lock_own_q;
        lock_cnt_d    = lock_cnt_q;
        req_addr_d    = req_addr_q;
        req_wr_data_d = req_wr_data_q;
        req_wr_en_d   = 1'b0;
        req_count_d   = `MEM_COUNT_NONE;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    // Capture the winner's request; the slave sees it next cycle.
                    state_d    = ST_ISSUE;
                    gnt_d      = grant_id_s;
                    lock_cnt_d = CNT_ZERO;
                    if (grant_id_s) begin
                        req_addr_d    = i_m1_addr;
                        req_wr_data_d = i_m1_wr_data;
                        req_wr_en_d   = i_m1_wr_en;
                        req_count_d   = i_m1_count;
                    end else begin
                        req_addr_d    = i_m0_addr;
                        req_wr_data_d = i_m0_wr_data;
                        req_wr_en_d   = i_m0_wr_en;
                        req_count_d   = i_m0_count;
                    end
                end else if (lock_q && !owner_req_s) begin
                    // Owner has gone quiet: age the lock and drop it on timeout.
                    if (lock_cnt_q == LOCK_LAST) begin
                        lock_d     = 1'b0;
                        lock_cnt_d = CNT_ZERO;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CNT_ONE;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
            end
            ST_RESP: begin
                state_d    = ST_IDLE;
                rr_d       = ~gnt_q;
                lock_d     = gnt_q ? i_m1_lock : i_m0_lock;
                lock_own_d = gnt_q;
                lock_cnt_d = CNT_ZERO;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            rr_q          <= 1'b0;
            gnt_q         <= 1'b0;
            lock_q        <= 1'b0;
            lock_own_q    <= 1'b0;
            lock_cnt_q    <= CNT_ZERO;
            req_addr_q    <= {`ADDR_W{1'b0}};
            req_wr_data_q <= {`WORD_W{1'b0}};
            req_wr_en_q   <= 1'b0;
            req_count_q   <= `MEM_COUNT_NONE;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            gnt_q         <= gnt_d;
            lock_q        <= lock_d;
            lock_own_q    <= lock_own_d;
            lock_cnt_q    <= lock_cnt_d;
            req_addr_q    <= req_addr_d;
            req_wr_data_q <= req_wr_data_d;
            req_wr_en_q   <= req_wr_en_d;
            req_count_q   <= req_count_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
        end
    end

    // Slave port is driven straight from the request registers.
    always_comb begin
        o_req_addr    = req_addr_q;
        o_req_wr_data = req_wr_data_q;
        o_req_wr_en   = req_wr_en_q;
        o_req_count   = req_count_q;
    end

    // Response steering: slave data goes only to the acknowledged master.
    always_comb begin
        o_m0_ack     = ack0_q;
        o_m1_ack     = ack1_q;
        o_m0_rd_data = {`WORD_W{1'b0}};
        o_m0_code    = {`MEM_CODE_W{1'b0}};
        o_m1_rd_data = {`WORD_W{1'b0}};
        o_m1_code    = {`MEM_CODE_W{1'b0}};
        if (ack0_q) begin
            o_m0_rd_data = i_res_rd_data;
            o_m0_code    = i_res_code;
        end else begin
            o_m0_rd_data = {`WORD_W{1'b0}};
            o_m0_code    = {`MEM_CODE_W{1'b0}};
        end
        if (ack1_q) begin
            o_m1_rd_data = i_res_rd_data;
            o_m1_code    = i_res_code;
        end else begin
            o_m1_rd_data = {`WORD_W{1'b0}};
            o_m1_code    = {`MEM_CODE_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: reset, single reads, round-robin,
// locked read-modify-write, lock timeout and reset during ISSUE.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 3'd1
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif

module tb_mmio_arbiter;

    logic                    clk = 1'b0;
    logic                    aresetn;
    logic                    m0_req, m0_wr_en, m0_lock;
    logic [`ADDR_W-1:0]      m0_addr;
    logic [`WORD_W-1:0]      m0_wr_data;
    logic [`MEM_COUNT_W-1:0] m0_count;
    logic                    m0_ack;
    logic [`WORD_W-1:0]      m0_rd_data;
    logic [`MEM_CODE_W-1:0]  m0_code;
    logic                    m1_req, m1_wr_en, m1_lock;
    logic [`ADDR_W-1:0]      m1_addr;
    logic [`WORD_W-1:0]      m1_wr_data;
    logic [`MEM_COUNT_W-1:0] m1_count;
    logic                    m1_ack;
    logic [`WORD_W-1:0]      m1_rd_data;
    logic [`MEM_CODE_W-1:0]  m1_code;
    logic [`ADDR_W-1:0]      req_addr;
    logic [`WORD_W-1:0]      req_wr_data;
    logic                    req_wr_en;
    logic [`MEM_COUNT_W-1:0] req_count;
    logic [`WORD_W-1:0]      res_rd_data;
    logic [`MEM_CODE_W-1:0]  res_code;

    int n_vec = 0;
    int n_err = 0;

    mmio_arbiter #(.LOCK_TIMEOUT(16), .LOCK_CNT_W(5)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .i_m0_req      (m0_req),
        .i_m0_addr     (m0_addr),
        .i_m0_wr_data  (m0_wr_data),
        .i_m0_wr_en    (m0_wr_en),
        .i_m0_count    (m0_count),
        .i_m0_lock     (m0_lock),
        .o_m0_ack      (m0_ack),
        .o_m0_rd_data  (m0_rd_data),
        .o_m0_code     (m0_code),
        .i_m1_req      (m1_req),
        .i_m1_addr     (m1_addr),
        .i_m1_wr_data  (m1_wr_data),
        .i_m1_wr_en    (m1_wr_en),
        .i_m1_count    (m1_count),
        .i_m1_lock     (m1_lock),
        .o_m1_ack      (m1_ack),
        .o_m1_rd_data  (m1_rd_data),
        .o_m1_code     (m1_code),
        .o_req_addr    (req_addr),
        .o_req_wr_data (req_wr_data),
        .o_req_wr_en   (req_wr_en),
        .o_req_count   (req_count),
        .i_res_rd_data (res_rd_data),
        .i_res_code    (res_code)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic seen;

        // ---- 1. reset with m0 requesting ----
        aresetn    = 1'b0;
        m0_req     = 1'b1;  m0_addr = 32'h4;  m0_wr_data = 32'h0;
        m0_wr_en   = 1'b0;  m0_count = `MEM_COUNT_WORD;  m0_lock = 1'b0;
        m1_req     = 1'b0;  m1_addr = 32'h0;  m1_wr_data = 32'h0;
        m1_wr_en   = 1'b0;  m1_count = `MEM_COUNT_NONE;  m1_lock = 1'b0;
        res_rd_data = 32'h0000_1234;  res_code = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("rst_count", req_count, `MEM_COUNT_NONE);
            chk_eq("rst_ack0", m0_ack, 1'b0);
        end
        chk_eq("rst_wr_en", req_wr_en, 1'b0);
        chk_eq("rst_addr", req_addr, 32'h0);
        chk_eq("rst_wdata", req_wr_data, 32'h0);
        chk_eq("rst_m0_rd", m0_rd_data, 32'h0);
        aresetn = 1'b1;                         // cycle k
        tick();                                 // k+1 ISSUE
        chk_eq("t1_ack0_k1", m0_ack, 1'b0);
        chk_eq("t1_count_k1", req_count, `MEM_COUNT_WORD);
        chk_eq("t1_addr_k1", req_addr, 32'h4);
        tick();                                 // k+2 RESP
        chk_eq("t1_ack0_k2", m0_ack, 1'b1);
        chk_eq("t1_rd_k2", m0_rd_data, 32'h0000_1234);
        m0_req = 1'b0;
        tick();
        chk_eq("t1_ack0_k3", m0_ack, 1'b0);

        // ---- 2. m0 read 0x8 WORD ----
        m0_addr = 32'h8;  m0_req = 1'b1;
        res_rd_data = 32'hdead_beef;  res_code = 2'd2;
        tick();
        chk_eq("t2_ack0_k1", m0_ack, 1'b0);
        chk_eq("t2_addr", req_addr, 32'h8);
        chk_eq("t2_count", req_count, `MEM_COUNT_WORD);
        chk_eq("t2_wr_en", req_wr_en, 1'b0);
        tick();
        chk_eq("t2_ack0", m0_ack, 1'b1);
        chk_eq("t2_rd", m0_rd_data, 32'hdead_beef);
        chk_eq("t2_code", m0_code, 2'd2);
        chk_eq("t2_ack1", m1_ack, 1'b0);
        chk_eq("t2_m1_rd", m1_rd_data, 32'h0);
        chk_eq("t2_count_resp", req_count, `MEM_COUNT_NONE);
        m0_req = 1'b0;
        tick();

        // ---- 6. reset during ISSUE (rr pointer currently at m1) ----
        m1_req = 1'b1;  m1_addr = 32'h10;  m1_wr_data = 32'h55;
        m1_wr_en = 1'b1;  m1_count = `MEM_COUNT_WORD;
        tick();
        chk_eq("t6_issue_wr_en", req_wr_en, 1'b1);
        chk_eq("t6_issue_count", req_count, `MEM_COUNT_WORD);
        #2;
        aresetn = 1'b0;
        #1;
        chk_eq("t6_abort_wr_en", req_wr_en, 1'b0);
        chk_eq("t6_abort_count", req_count, `MEM_COUNT_NONE);
        chk_eq("t6_abort_addr", req_addr, 32'h0);
        m1_req = 1'b0;  m1_wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_eq("t6_no_ack1", m1_ack, 1'b0);
        end
        aresetn = 1'b1;

        // ---- 3. both masters request continuously: m0 first after reset ----
        m0_req = 1'b1;  m0_addr = 32'h20;
        m1_req = 1'b1;  m1_addr = 32'h24;  m1_count = `MEM_COUNT_WORD;
        res_rd_data = 32'ha5a5_5a5a;  res_code = 2'd1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk_eq($sformatf("t3_ack0_c%0d", c), m0_ack, (c == 2 || c == 8) ? 1'b1 : 1'b0);
            chk_eq($sformatf("t3_ack1_c%0d", c), m1_ack, (c == 5 || c == 11) ? 1'b1 : 1'b0);
            if (c == 5)
                chk_eq("t3_m1_rd", m1_rd_data, 32'ha5a5_5a5a);
        end
        m0_req = 1'b0;  m1_req = 1'b0;
        tick();

        // ---- 4. m1 locked read-modify-write while m0 waits ----
        m1_req = 1'b1;  m1_addr = 32'h0;  m1_wr_en = 1'b0;
        m1_count = `MEM_COUNT_WORD;  m1_lock = 1'b1;
        tick();                                 // k+1 ISSUE
        m0_req = 1'b1;  m0_addr = 32'h30;
        tick();                                 // k+2 RESP
        chk_eq("t4_ack1_read", m1_ack, 1'b1);
        chk_eq("t4_ack0_read", m0_ack, 1'b0);
        tick();                                 // k+3 IDLE: switch m1 to the write
        m1_wr_en = 1'b1;  m1_count = `MEM_COUNT_BYTE;
        m1_wr_data = 32'h2;  m1_lock = 1'b0;
        chk_eq("t4_ack_idle", {m0_ack, m1_ack}, 2'b00);
        tick();                                 // k+4 ISSUE
        chk_eq("t4_w_addr", req_addr, 32'h0);
        chk_eq("t4_w_data", req_wr_data, 32'h2);
        chk_eq("t4_w_en", req_wr_en, 1'b1);
        chk_eq("t4_w_count", req_count, `MEM_COUNT_BYTE);
        tick();                                 // k+5 RESP
        chk_eq("t4_ack1_write", m1_ack, 1'b1);
        chk_eq("t4_ack0_write", m0_ack, 1'b0);
        m1_req = 1'b0;  m1_wr_en = 1'b0;
        tick();                                 // k+6 IDLE
        tick();                                 // k+7 ISSUE
        chk_eq("t4_m0_addr", req_addr, 32'h30);
        chk_eq("t4_m0_count", req_count, `MEM_COUNT_WORD);
        tick();                                 // k+8 RESP
        chk_eq("t4_ack0_last", m0_ack, 1'b1);
        chk_eq("t4_ack1_last", m1_ack, 1'b0);
        m0_req = 1'b0;
        tick();

        // ---- 5. m0 locks then idles; m1 stalls until timeout ----
        m0_req = 1'b1;  m0_addr = 32'h40;  m0_lock = 1'b1;
        tick();
        m1_req = 1'b1;  m1_addr = 32'h44;  m1_wr_en = 1'b0;
        tick();                                 // m0 RESP, lock sampled high
        chk_eq("t5_ack0", m0_ack, 1'b1);
        m0_req = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            m0_lock = 1'b0;
            if (n == 8)
                chk_eq("t5_stall_count", req_count, `MEM_COUNT_NONE);
            if (m0_ack)
                chk_eq("t5_no_ack0", m0_ack, 1'b0);
            seen = m1_ack;
        end
        chk_eq("t5_lock_wait", n, 19);
        m1_req = 1'b0;
        tick();
        chk_eq("t5_ack1_clear", m1_ack, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
